div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider serving the execute stage for DIV/DIVU/MOD/MODU.
//  Execute stage holds the pipeline (stall) while this block iterates.
//  Handshake uses div_start/div_valid1/div_valid2 in and cnt/div_ready out.
//  Returns {quotient, remainder} on a 64-bit bus; execute selects the half.
// PARAMETERS
//  WIDTH      32   operand width; cnt counts 1..WIDTH during iteration
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-low reset (0 = reset)
//  dividend     in   32     dividend; sampled only on accept
//  divisor      in   32     divisor; sampled only on accept
//  div_valid1   in   1      dividend valid
//  div_valid2   in   1      divisor valid
//  div_signed   in   1      1 = signed (DIV/MOD), 0 = unsigned; sampled on accept
//  div_start    in   1      held 1 by execute for the whole operation; 0 = cancel
//  div_ready    out  1      one-cycle pulse: div_result valid
//  div_result   out  64     [63:32] quotient, [31:0] remainder
//  cnt          out  32     0 when idle/done, 1..WIDTH while iterating
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, div_ready=0, div_result=0; all internal regs cleared.
//  States: IDLE, BUSY, DONE.
//  IDLE: accept when div_start & div_valid1 & div_valid2. Latch |dividend|, |divisor|,
//   sign flags (operand sign only when div_signed). Next state BUSY, cnt<=1.
//   If latched divisor==0: next state DONE directly, result q=32'hFFFF_FFFF, r=dividend (raw).
//  BUSY: one restoring step per cycle: shift {rem,quo} left 1; if rem>=divisor,
//   subtract and set quo[0]. Remainder path is 33 bits wide (no overflow).
//   cnt increments each cycle; on the step with cnt==WIDTH go to DONE, cnt<=0.
//  DONE: div_ready=1 for exactly one cycle; div_result = sign-fixed values:
//   quotient negated iff signed and signs differ; remainder takes dividend sign.
//   -2^31 / -1 (signed) -> q=32'h8000_0000, r=0 (no trap). Next state IDLE.
//  Latency: accept edge -> div_ready high WIDTH+1 cycles later (33 cycles).
//  div_result holds its value after DONE until the next DONE; not cleared in IDLE.
//  Cancel: div_start==0 while BUSY -> IDLE next edge, cnt<=0, no div_ready pulse.
//  Valid inputs while BUSY/DONE are ignored; operand changes mid-op do not affect result.
//  Accept in the cycle after DONE is legal (back-to-back divides).
//  Async reset mid-operation aborts immediately; no pulse after reset release.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: on accept, if |dividend| < |divisor| (divisor!=0),
//   skip BUSY: go straight to DONE, q=0, r=dividend; div_ready 1 cycle after accept.
//  DIV_EARLY_OUT_EN undefined: every nonzero-divisor op takes full WIDTH iterations.
// STRUCTURE
//  defines.v: state encodings DIV_IDLE/DIV_BUSY/DIV_DONE (2'b00/01/10),
//   DIV_ZERO_QUO (32'hFFFF_FFFF).
//  One combinational sub-module div_sign_fix: raw q/r + sign flags -> signed q/r.
//  Iteration datapath and FSM stay in div_iter.
// TESTING
//  100 / 7 unsigned -> ready at +33 cycles, result {32'd14, 32'd2}; cnt 1..32 then 0.
//  -7 / 2 signed -> q=32'hFFFF_FFFD, r=32'hFFFF_FFFF; 7 / -2 -> q=-3, r=1.
//  x / 0 (signed and unsigned) -> ready next cycle, q=32'hFFFF_FFFF, r=x.
//  32'h8000_0000 / 32'hFFFF_FFFF signed -> q=32'h8000_0000, r=0;
//   same operands unsigned -> q=0, r=32'h8000_0000.
//  Drop div_start at cnt=10 -> IDLE, cnt=0, no ready pulse; immediate new op correct.
//  DIV_EARLY_OUT_EN: 3 / 10 -> ready 1 cycle after accept, {0,3};
//   without macro -> ready at +33, same result.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative divider.
// Optional build macro: DIV_EARLY_OUT_EN (early completion when |dividend| < |divisor|).
package div_iter_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned CNT_W = 32;

    // Quotient returned for a zero divisor
    localparam logic [WIDTH-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Result bus: quotient in the upper half, remainder in the lower half
    typedef struct packed {
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] rem;
    } div_res_t;

    // Two's-complement negate when neg is set, pass-through otherwise
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/div_iter_sign_fix.sv
// Applies the final signs to the unsigned quotient/remainder of the divider.
module div_iter_sign_fix
    import div_iter_pkg::*;
(
    input  logic [WIDTH-1:0] quo_raw,
    input  logic [WIDTH-1:0] rem_raw,
    input  logic             neg_quo,
    input  logic             neg_rem,
    output logic [WIDTH-1:0] quo_c,
    output logic [WIDTH-1:0] rem_c
);

    // Quotient negated when operand signs differ; remainder follows the dividend
    always_comb begin
        quo_c = cond_neg(quo_raw, neg_quo);
        rem_c = cond_neg(rem_raw, neg_rem);
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/MOD/MODU.
// Build macro DIV_EARLY_OUT_EN: finish straight after accept when |dividend| < |divisor|.
module div_iter
    import div_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_valid1,
    input  logic             div_valid2,
    input  logic             div_signed,
    input  logic             div_start,
    output logic             div_ready,
    output logic [RES_W-1:0] div_result,
    output logic [CNT_W-1:0] cnt
);

    div_state_e       state, state_d;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] rem, rem_d;
    logic [WIDTH-1:0] quo, quo_d;
    logic [WIDTH-1:0] dvsr, dvsr_d;
    logic             neg_quo, neg_quo_d;
    logic             neg_rem, neg_rem_d;
    logic             zero_div, zero_div_d;
    logic             ready_d;
    div_res_t         res_q, res_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic             early_c;
    logic [WIDTH-1:0] fix_quo_c, fix_rem_c;

    // Operand magnitudes and the trial subtraction of one restoring step
    assign accept   = div_start & div_valid1 & div_valid2;
    assign a_neg    = div_signed & dividend[WIDTH-1];
    assign b_neg    = div_signed & divisor[WIDTH-1];
    assign abs_a    = cond_neg(dividend, a_neg);
    assign abs_b    = cond_neg(divisor, b_neg);
    assign trial    = {rem, quo[WIDTH-1]};
    assign trial_ge = (trial >= {1'b0, dvsr});

`ifdef DIV_EARLY_OUT_EN
    assign early_c = (abs_a < abs_b);
`else
    assign early_c = 1'b0;
`endif

    div_iter_sign_fix u_sign_fix (
        .quo_raw (quo),
        .rem_raw (rem),
        .neg_quo (neg_quo),
        .neg_rem (neg_rem),
        .quo_c   (fix_quo_c),
        .rem_c   (fix_rem_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            zero_div  <= 1'b0;
            div_ready <= 1'b0;
            res_q     <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rem       <= rem_d;
            quo       <= quo_d;
            dvsr      <= dvsr_d;
            neg_quo   <= neg_quo_d;
            neg_rem   <= neg_rem_d;
            zero_div  <= zero_div_d;
            div_ready <= ready_d;
            res_q     <= res_d;
        end
    end

    // Next-state, iteration step and result update
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        rem_d      = rem;
        quo_d      = quo;
        dvsr_d     = dvsr;
        neg_quo_d  = neg_quo;
        neg_rem_d  = neg_rem;
        zero_div_d = zero_div;
        ready_d    = 1'b0;
        res_d      = res_q;

        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    dvsr_d     = abs_b;
                    neg_quo_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    zero_div_d = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor bypasses sign fixing: raw dividend comes back
                        zero_div_d = 1'b1;
                        quo_d      = DIV_ZERO_QUO;
                        rem_d      = dividend;
                        cnt_d      = '0;
                        state_d    = DIV_DONE;
                    end else if (early_c) begin
                        // Sign fix turns |dividend| back into the raw dividend
                        quo_d   = '0;
                        rem_d   = abs_a;
                        cnt_d   = '0;
                        state_d = DIV_DONE;
                    end else begin
                        quo_d   = abs_a;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(1);
                        state_d = DIV_BUSY;
                    end
                end
            end

            DIV_BUSY: begin
                if (!div_start) begin
                    cnt_d   = '0;
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = trial_ge ? WIDTH'(trial - {1'b0, dvsr}) : trial[WIDTH-1:0];
                    quo_d = {quo[WIDTH-2:0], trial_ge};
                    if (cnt == CNT_W'(WIDTH)) begin
                        cnt_d   = '0;
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end

            DIV_DONE: begin
                ready_d = 1'b1;
                if (zero_div) begin
                    res_d.quo = quo;
                    res_d.rem = rem;
                end else begin
                    res_d.quo = fix_quo_c;
                    res_d.rem = fix_rem_c;
                end
                state_d = DIV_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign div_result = res_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter against an arithmetic reference model.
module tb_div_iter;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_valid1 = 1'b0;
    logic        div_valid2 = 1'b0;
    logic        div_signed = 1'b0;
    logic        div_start = 1'b0;
    logic        div_ready;
    logic [63:0] div_result;
    logic [31:0] cnt;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] op_a, op_b;
    logic        op_s;

    div_iter dut (
        .clk        (clk),
        .rst        (rst),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_valid1 (div_valid1),
        .div_valid2 (div_valid2),
        .div_signed (div_signed),
        .div_start  (div_start),
        .div_ready  (div_ready),
        .div_result (div_result),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    // Reference result from plain integer division (truncating, remainder takes dividend sign)
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Reference latency in cycles from the accept edge to div_ready
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint ma, mb;
        if (b == 32'd0) return 1;
        ma = s ? longint'($signed(a)) : longint'({32'd0, a});
        mb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (EARLY && (ma < mb)) return 1;
        return 33;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        op_a       = a;
        op_b       = b;
        op_s       = s;
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_valid1 = 1'b1;
        div_valid2 = 1'b1;
        div_start  = 1'b1;
    endtask

    // Waits through the accept edge and the operation, checking cnt, latency and result
    task automatic finish_op(input string tag);
        logic [63:0] exp_res;
        int          exp_lat;
        int          m;
        bit          seen;
        exp_res = ref_div(op_a, op_b, op_s);
        exp_lat = ref_lat(op_a, op_b, op_s);
        seen    = 1'b0;
        m       = 0;
        @(posedge clk); #1;
        div_valid1 = 1'($urandom);
        div_valid2 = 1'($urandom);
        dividend   = $urandom;
        divisor    = $urandom;
        div_signed = 1'($urandom);
        check({tag, "/cnt0"}, 64'(cnt), (exp_lat == 1) ? 64'd0 : 64'd1);
        while (!seen && m < 40) begin
            @(posedge clk); #1;
            m++;
            check({tag, "/cnt"}, 64'(cnt), (exp_lat == 1 || m >= 32) ? 64'd0 : 64'(m + 1));
            if (div_ready) seen = 1'b1;
        end
        check({tag, "/ready_seen"}, 64'(seen), 64'd1);
        check({tag, "/latency"}, 64'(m), 64'(exp_lat));
        check({tag, "/result"}, div_result, exp_res);
    endtask

    task automatic go_idle(input string tag);
        div_start  = 1'b0;
        div_valid1 = 1'b0;
        div_valid2 = 1'b0;
        @(posedge clk); #1;
        check({tag, "/pulse_end"}, 64'(div_ready), 64'd0);
    endtask

    initial begin
        int          k;
        int          pulses;
        logic [31:0] ra, rb;
        logic        rs;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst/cnt", 64'(cnt), 64'd0);
        check("rst/ready", 64'(div_ready), 64'd0);
        check("rst/result", div_result, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed operations
        start_op(32'd100, 32'd7, 1'b0);
        finish_op("u100_7");
        check("u100_7/literal", div_result, {32'd14, 32'd2});
        go_idle("u100_7");

        start_op(-32'sd7, 32'd2, 1'b1);
        finish_op("s-7_2");
        check("s-7_2/literal", div_result, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        go_idle("s-7_2");

        start_op(32'd7, -32'sd2, 1'b1);
        finish_op("s7_-2");
        go_idle("s7_-2");

        start_op(32'hFFFF_FFF0, 32'd0, 1'b1);
        finish_op("s_div0");
        go_idle("s_div0");

        start_op(32'hDEAD_BEEF, 32'd0, 1'b0);
        finish_op("u_div0");
        check("u_div0/literal", div_result, {32'hFFFF_FFFF, 32'hDEAD_BEEF});
        go_idle("u_div0");

        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_op("s_min_-1");
        check("s_min_-1/literal", div_result, {32'h8000_0000, 32'd0});
        go_idle("s_min_-1");

        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        finish_op("u_min_-1");
        go_idle("u_min_-1");

        start_op(32'd3, 32'd10, 1'b0);
        finish_op("u3_10");
        check("u3_10/literal", div_result, {32'd0, 32'd3});
        go_idle("u3_10");

        start_op(-32'sd3, 32'd10, 1'b1);
        finish_op("s-3_10");
        go_idle("s-3_10");

        // Back-to-back: accept in the cycle div_ready is high
        start_op(32'd1000, 32'd3, 1'b0);
        finish_op("b2b_a");
        start_op(-32'sd1000, 32'd7, 1'b1);
        finish_op("b2b_b");
        start_op(32'd5, 32'd0, 1'b0);
        finish_op("b2b_c");
        go_idle("b2b_c");

        // Cancel at cnt==10, then an immediate new operation
        start_op(32'd12345, 32'd67, 1'b0);
        @(posedge clk); #1;
        div_valid1 = 1'b0;
        div_valid2 = 1'b0;
        k = 0;
        while (cnt != 32'd10 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("cancel/reach_cnt10", 64'(cnt), 64'd10);
        div_start = 1'b0;
        @(posedge clk); #1;
        check("cancel/cnt", 64'(cnt), 64'd0);
        check("cancel/ready", 64'(div_ready), 64'd0);
        start_op(32'd999, 32'd9, 1'b0);
        finish_op("after_cancel");
        go_idle("after_cancel");

        // Asynchronous reset in the middle of an operation
        start_op(32'd555, 32'd5, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst/cnt", 64'(cnt), 64'd0);
        check("midrst/ready", 64'(div_ready), 64'd0);
        check("midrst/result", div_result, 64'd0);
        div_start  = 1'b0;
        div_valid1 = 1'b0;
        div_valid2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_ready) pulses++;
        end
        check("midrst/no_pulse", 64'(pulses), 64'd0);

        // Randomized operations, mixing idle gaps and back-to-back accepts
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            rs = 1'($urandom);
            start_op(ra, rb, rs);
            finish_op($sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 0) go_idle($sformatf("rand%0d", i));
        end
        go_idle("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
